// File: rtl/paint_queue.sv
// Buffered cell-paint request FIFO feeding the box painter's start/busy/done handshake.
// Optional macro PAINT_QUEUE_COALESCE_EN merges a repeated (x,y) into the pending tail entry.
module paint_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CELL_W = 64,
   parameter int unsigned CELL_H = 24,
   parameter int unsigned GRID_W = 10,
   parameter int unsigned GRID_H = 20
) (
   input  logic                      CLOCK_50,
   input  logic                      resetn,
   input  logic                      req_valid,
   input  logic [3:0]                req_x,
   input  logic [4:0]                req_y,
   input  logic [8:0]                req_color,
   output logic                      req_ready,
   input  logic                      flush,
   output logic                      start,
   output logic [9:0]                x0,
   output logic [8:0]                y0,
   output logic [8:0]                color,
   input  logic                      busy,
   input  logic                      done,
   output logic [$clog2(DEPTH):0]    q_count,
   output logic                      idle,
   output logic                      range_err
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned XSH = $clog2(CELL_W);

   typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [9:0]    x0_q, x0_d;
   logic [8:0]    y0_q, y0_d;
   logic [8:0]    color_q, color_d;
   logic          range_err_q, range_err_d;

   logic [3:0]    mem_x [DEPTH];
   logic [4:0]    mem_y [DEPTH];
   logic [8:0]    mem_c [DEPTH];

   logic          in_range, accept, push, pop, coalesce;
`ifdef PAINT_QUEUE_COALESCE_EN
   logic [AW-1:0] tail;
   assign tail = wr_ptr_q - AW'(1);
`endif

   assign req_ready = (count_q != CW'(DEPTH));
   assign q_count   = count_q;
   assign idle      = (count_q == '0) && (state_q == StIdle);
   assign x0        = x0_q;
   assign y0        = y0_q;
   assign color     = color_q;
   assign range_err = range_err_q;

   always_comb begin
      in_range    = (32'(req_x) < GRID_W) && (32'(req_y) < GRID_H);
      accept      = req_valid && req_ready && !flush;
      // Flush wins over a pop so nothing queued is launched in the flush cycle.
      pop         = (state_q == StIdle) && (count_q != '0) && !busy && !flush;
`ifdef PAINT_QUEUE_COALESCE_EN
      coalesce    = accept && in_range && (count_q != '0) &&
                    (mem_x[tail] == req_x) && (mem_y[tail] == req_y) &&
                    !(pop && (count_q == CW'(1)));
`else
      coalesce    = 1'b0;
`endif
      push        = accept && in_range && !coalesce;
      range_err_d = range_err_q | (accept & ~in_range);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      color_d = color_q;
      start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               x0_d    = 10'(32'(mem_x[rd_ptr_q]) << XSH);
               y0_d    = 9'(32'(mem_y[rd_ptr_q]) * CELL_H);
               color_d = mem_c[rd_ptr_q];
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            start   = 1'b1;
            state_d = StWaitDone;
         end
         StWaitDone: begin
            if (done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         x0_q        <= '0;
         y0_q        <= '0;
         color_q     <= '0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         color_q     <= color_d;
         range_err_q <= range_err_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         mem_x[wr_ptr_q] <= req_x;
         mem_y[wr_ptr_q] <= req_y;
         mem_c[wr_ptr_q] <= req_color;
      end
`ifdef PAINT_QUEUE_COALESCE_EN
      if (coalesce) mem_c[tail] <= req_color;
`endif
   end

endmodule
